// File: rtl/processor_pkg.sv
// ============================================================================
//  Module      : processor_pkg
//  Description : Shared decode constants, multiply/divide status codes and
//                FSM state encoding for the execute-stage mul/div unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package processor_pkg;

    localparam logic [4:0] OPC_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_MUL   = 5'b00110;
    localparam logic [4:0] ALU_DIV   = 5'b00111;

    localparam logic [31:0] STATUS_MUL = 32'd4;
    localparam logic [31:0] STATUS_DIV = 32'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    // |INT_MIN| yields 32'h80000000, which is the correct unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multdiv_unit_if.sv
// ============================================================================
//  Module      : multdiv_unit_if
//  Description : Execute-stage <-> mul/div unit signal bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multdiv_unit_if;

    logic [31:0] instruction_dx_in;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] instruction_multdiv;
    logic [31:0] multdiv_output;
    logic        multdiv_ready;
    logic        multdiv_exception;
    logic        multdiv_stall;

    modport master (
        output instruction_dx_in, data_operandA, data_operandB,
        input  instruction_multdiv, multdiv_output, multdiv_ready,
               multdiv_exception, multdiv_stall
    );

    modport slave (
        input  instruction_dx_in, data_operandA, data_operandB,
        output instruction_multdiv, multdiv_output, multdiv_ready,
               multdiv_exception, multdiv_stall
    );

endinterface

`default_nettype wire

// File: rtl/multdiv_iter_core.sv
// ============================================================================
//  Module      : multdiv_iter_core
//  Description : One-bit-per-cycle unsigned shift-add multiply / restoring
//                divide datapath operating on operand magnitudes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_iter_core (
    input  wire logic        clock,
    input  wire logic        reset,
    input  wire logic        i_load,
    input  wire logic        i_step,
    input  wire logic        i_op_div,
    input  wire logic [31:0] i_mag_a,
    input  wire logic [31:0] i_mag_b,
    output logic      [63:0] o_result_mag,
    output logic             o_overflow
);

    // mul: r_acc = {partial hi, multiplier lo}; div: r_acc[31:0] = remainder
    logic [63:0] r_acc;
    logic [31:0] r_quo;
    logic [31:0] r_opnd;
    logic        r_op_div;

    logic [32:0] w_sum;
    logic [32:0] w_trial;
    logic [31:0] w_diff;
    logic        w_q_bit;
    logic [31:0] w_rem_next;

    assign w_sum      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_trial    = {r_acc[31:0], r_quo[31]};
    assign w_q_bit    = (w_trial >= {1'b0, r_opnd});
    assign w_diff     = w_trial[31:0] - r_opnd;
    assign w_rem_next = w_q_bit ? w_diff : w_trial[31:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc    <= 64'd0;
            r_quo    <= 32'd0;
            r_opnd   <= 32'd0;
            r_op_div <= 1'b0;
        end else if (i_load) begin
            r_op_div <= i_op_div;
            r_opnd   <= i_op_div ? i_mag_b : i_mag_a;
            r_acc    <= i_op_div ? 64'd0 : {32'd0, i_mag_b};
            r_quo    <= i_op_div ? i_mag_a : 32'd0;
        end else if (i_step) begin
            if (r_op_div) begin
                r_acc <= {32'd0, w_rem_next};
                r_quo <= {r_quo[30:0], w_q_bit};
            end else begin
                r_acc <= {w_sum, r_acc[31:1]};
            end
        end
    end

    // Overflow: div-by-zero for div, magnitude beyond 31 bits for mul.
    assign o_result_mag = r_op_div ? {32'd0, r_quo} : r_acc;
    assign o_overflow   = r_op_div ? (r_opnd == 32'd0) : (|r_acc[63:31]);

endmodule

`default_nettype wire

// File: rtl/multdiv_unit.sv
// ============================================================================
//  Module      : multdiv_unit
//  Description : Iterative signed multiply/divide unit beside the execute
//                stage. Optional MULTDIV_FAST_DIV0_EN retires div-by-zero
//                one cycle after accept instead of after full iteration.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_unit
    import processor_pkg::*;
#(
    parameter int          ITER_CYCLES = 32,
    parameter logic [31:0] MUL_STATUS  = STATUS_MUL,
    parameter logic [31:0] DIV_STATUS  = STATUS_DIV
) (
    input  wire logic     clock,
    input  wire logic     reset,
    multdiv_unit_if.slave mdu
);

    localparam int             CNT_W = $clog2(ITER_CYCLES);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ITER_CYCLES - 1);

    mdu_state_t       r_state;
    mdu_state_t       w_state_next;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_instr;
    logic             r_op_div;
    logic             r_neg;

    logic [4:0]  w_opcode;
    logic [4:0]  w_alu_op;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_start;
    logic        w_accept;
    logic        w_fast_done;
    logic [63:0] w_core_mag;
    logic        w_core_ovf;
    logic [31:0] w_signed_res;
    logic        w_exc;

    assign w_opcode = mdu.instruction_dx_in[31:27];
    assign w_alu_op = mdu.instruction_dx_in[6:2];
    assign w_is_mul = (w_opcode == OPC_RTYPE) && (w_alu_op == ALU_MUL);
    assign w_is_div = (w_opcode == OPC_RTYPE) && (w_alu_op == ALU_DIV);
    assign w_start  = w_is_mul || w_is_div;
    assign w_accept = w_start && (r_state != BUSY);

`ifdef MULTDIV_FAST_DIV0_EN
    assign w_fast_done = w_is_div && (mdu.data_operandB == 32'd0);
`else
    assign w_fast_done = 1'b0;
`endif

    multdiv_iter_core u_core (
        .clock        (clock),
        .reset        (reset),
        .i_load       (w_accept),
        .i_step       (r_state == BUSY),
        .i_op_div     (w_is_div),
        .i_mag_a      (magnitude(mdu.data_operandA)),
        .i_mag_b      (magnitude(mdu.data_operandB)),
        .o_result_mag (w_core_mag),
        .o_overflow   (w_core_ovf)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_instr  <= 32'd0;
            r_op_div <= 1'b0;
            r_neg    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_instr  <= mdu.instruction_dx_in;
                r_op_div <= w_is_div;
                r_neg    <= mdu.data_operandA[31] ^ mdu.data_operandB[31];
                r_count  <= '0;
            end else if (r_state == BUSY) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // A negative product of exactly 2^31 is INT_MIN and still fits.
    assign w_signed_res = r_neg ? (~w_core_mag[31:0] + 32'd1) : w_core_mag[31:0];
    assign w_exc        = r_op_div ? w_core_ovf
                                   : (w_core_ovf && !(r_neg && (w_core_mag == 64'h8000_0000)));

    always_comb begin
        w_state_next          = r_state;
        mdu.multdiv_ready     = 1'b0;
        mdu.multdiv_exception = 1'b0;
        mdu.multdiv_output    = 32'd0;
        unique case (r_state)
            IDLE, DONE: begin
                if (w_accept) w_state_next = w_fast_done ? DONE : BUSY;
                else          w_state_next = IDLE;
            end
            BUSY:    if (r_count == C_LAST) w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
        if (r_state == DONE) begin
            mdu.multdiv_ready     = 1'b1;
            mdu.multdiv_exception = w_exc;
            mdu.multdiv_output    = w_exc ? (r_op_div ? DIV_STATUS : MUL_STATUS) : w_signed_res;
        end
        mdu.multdiv_stall = !reset && ((w_start && (r_state != BUSY)) || (r_state == BUSY));
    end

    assign mdu.instruction_multdiv = r_instr;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_unit.sv
// ============================================================================
//  Module      : tb_multdiv_unit
//  Description : Self-checking bench for multdiv_unit (directed table,
//                randomized ops against a 64-bit arithmetic reference).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multdiv_unit;

`ifdef MULTDIV_FAST_DIV0_EN
    localparam int DIV0_LAT = 1;
`else
    localparam int DIV0_LAT = 33;
`endif
    localparam logic [31:0] IDLE_INSTR = 32'h0000_0000;

    logic clock;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;

    multdiv_unit_if bus ();

    multdiv_unit dut (
        .clock (clock),
        .reset (reset),
        .mdu   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        bit          exc;
        string       name;
    } vec_t;

    vec_t vt[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] make_instr(input bit div, input logic [4:0] rd);
        logic [31:0] v;
        v        = $urandom;
        v[31:27] = 5'b00000;
        v[26:22] = rd;
        v[6:2]   = div ? 5'b00111 : 5'b00110;
        return v;
    endfunction

    // Reference: exact signed arithmetic in 64 bits, status codes on error.
    function automatic void ref_model(input bit div, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] out, output bit exc);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!div) begin
            r   = sa * sb;
            exc = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            out = exc ? 32'd4 : r[31:0];
        end else if (sb == 0) begin
            exc = 1'b1;
            out = 32'd5;
        end else begin
            r   = sa / sb;
            exc = 1'b0;
            out = r[31:0];
        end
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 1000));
            4:       return -32'($urandom_range(1, 1000));
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input bit div, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_out, input bit exp_exc, input string name);
        logic [31:0] instr;
        int          c0, lat, exp_lat, stall_bad;
        bit          seen;
        instr     = make_instr(div, 5'($urandom_range(1, 31)));
        exp_lat   = (div && b == 32'd0) ? DIV0_LAT : 33;
        stall_bad = 0;
        seen      = 1'b0;
        lat       = -1;
        @(posedge clock); #1;
        bus.instruction_dx_in = instr;
        bus.data_operandA     = a;
        bus.data_operandB     = b;
        c0 = cyc;
        @(negedge clock);
        if (bus.multdiv_stall !== 1'b1 || bus.multdiv_ready !== 1'b0) stall_bad++;
        @(posedge clock); #1;
        // operands are scrambled after accept; the result must not follow them
        bus.instruction_dx_in = IDLE_INSTR;
        bus.data_operandA     = $urandom;
        bus.data_operandB     = $urandom;
        while (!seen && (cyc - c0) <= 40) begin
            @(negedge clock);
            if (bus.multdiv_ready === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - c0;
            end
            if (bus.multdiv_stall !== ((cyc - c0) < exp_lat)) stall_bad++;
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " stall"}, stall_bad, 0);
        check({name, " output"}, bus.multdiv_output, exp_out);
        check({name, " exception"}, {31'd0, bus.multdiv_exception}, {31'd0, exp_exc});
        check({name, " instr"}, bus.instruction_multdiv, instr);
    endtask

    task automatic wait_ready(input int c_start, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int k = 0; k < 45 && !seen; k++) begin
            @(negedge clock);
            if (bus.multdiv_ready === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - c_start;
            end
        end
    endtask

    initial begin
        logic [31:0] eo, i1, i2;
        bit          ee;
        int          c0, c1, lat, n_ready, n_stall;
        logic        rdiv;
        logic [31:0] ra, rb;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.instruction_dx_in = IDLE_INSTR;
        bus.data_operandA     = 32'd0;
        bus.data_operandB     = 32'd0;

        vt[0]  = '{0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, "mul_7_x_m3"};
        vt[1]  = '{0, 32'h0001_0000, 32'h0001_0000, 32'd4,        1, "mul_2p16_sq"};
        vt[2]  = '{1, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFF2, 0, "div_m100_7"};
        vt[3]  = '{1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "div_intmin_m1"};
        vt[4]  = '{1, 32'd5,        32'd0,         32'd5,        1, "div_5_0"};
        vt[5]  = '{0, 32'h8000_0000, 32'd1,        32'h8000_0000, 0, "mul_intmin_1"};
        vt[6]  = '{0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd4,        1, "mul_intmin_m1"};
        vt[7]  = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,        0, "mul_m1_m1"};
        vt[8]  = '{1, 32'd100,      32'hFFFF_FFF9, 32'hFFFF_FFF2, 0, "div_100_m7"};
        vt[9]  = '{1, 32'd7,        32'd100,       32'd0,        0, "div_7_100"};
        vt[10] = '{0, 32'd46341,    32'd46341,     32'd4,        1, "mul_46341_sq"};
        vt[11] = '{0, 32'h7FFF_FFFF, 32'd1,        32'h7FFF_FFFF, 0, "mul_intmax_1"};
        vt[12] = '{0, 32'd0,        32'hFFFF_FFFB, 32'd0,        0, "mul_0_m5"};
        vt[13] = '{1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 0, "div_m7_2"};

        repeat (2) @(negedge clock);
        check("reset ready", {31'd0, bus.multdiv_ready}, 32'd0);
        check("reset stall", {31'd0, bus.multdiv_stall}, 32'd0);
        check("reset output", bus.multdiv_output, 32'd0);
        check("reset exception", {31'd0, bus.multdiv_exception}, 32'd0);
        check("reset instr", bus.instruction_multdiv, 32'd0);
        reset = 1'b0;

        foreach (vt[i]) do_op(vt[i].div, vt[i].a, vt[i].b, vt[i].out, vt[i].exc, vt[i].name);

        // Back-to-back with a start pulse that lands mid-BUSY and must be ignored.
        i1 = make_instr(1'b0, 5'd3);
        @(posedge clock); #1;
        bus.instruction_dx_in = i1;
        bus.data_operandA     = 32'd1234;
        bus.data_operandB     = 32'hFFFF_FFC8;
        c0 = cyc;
        @(posedge clock); #1;
        bus.instruction_dx_in = IDLE_INSTR;
        repeat (8) @(posedge clock);
        #1;
        bus.instruction_dx_in = make_instr(1'b1, 5'd9);
        bus.data_operandA     = 32'd100;
        bus.data_operandB     = 32'd3;
        @(posedge clock); #1;
        bus.instruction_dx_in = IDLE_INSTR;
        wait_ready(c0, lat);
        ref_model(1'b0, 32'd1234, 32'hFFFF_FFC8, eo, ee);
        check("b2b first latency", lat, 33);
        check("b2b first output", bus.multdiv_output, eo);
        check("b2b first instr", bus.instruction_multdiv, i1);
        i2 = make_instr(1'b0, 5'd17);
        bus.instruction_dx_in = i2;
        bus.data_operandA     = 32'hFFFF_FFF7;
        bus.data_operandB     = 32'd11;
        c1 = cyc;
        #1;
        check("b2b stall in done", {31'd0, bus.multdiv_stall}, 32'd1);
        @(posedge clock); #1;
        bus.instruction_dx_in = IDLE_INSTR;
        wait_ready(c1, lat);
        ref_model(1'b0, 32'hFFFF_FFF7, 32'd11, eo, ee);
        check("b2b second latency", lat, 33);
        check("b2b second output", bus.multdiv_output, eo);
        check("b2b second instr", bus.instruction_multdiv, i2);

        // Asynchronous reset while count == 15.
        @(posedge clock); #1;
        bus.instruction_dx_in = make_instr(1'b0, 5'd5);
        bus.data_operandA     = 32'd3;
        bus.data_operandB     = 32'd4;
        c0 = cyc;
        @(posedge clock); #1;
        bus.instruction_dx_in = IDLE_INSTR;
        while ((cyc - c0) < 16) @(negedge clock);
        check("pre-reset stall", {31'd0, bus.multdiv_stall}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort ready", {31'd0, bus.multdiv_ready}, 32'd0);
        check("abort stall", {31'd0, bus.multdiv_stall}, 32'd0);
        check("abort output", bus.multdiv_output, 32'd0);
        check("abort exception", {31'd0, bus.multdiv_exception}, 32'd0);
        check("abort instr", bus.instruction_multdiv, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        // Non-R-type opcode carrying the mul ALU field must not start anything.
        @(posedge clock); #1;
        bus.instruction_dx_in = 32'h0800_0018;
        @(negedge clock);
        check("non-rtype stall", {31'd0, bus.multdiv_stall}, 32'd0);
        @(posedge clock); #1;
        bus.instruction_dx_in = IDLE_INSTR;
        n_ready = 0;
        n_stall = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.multdiv_ready !== 1'b0) n_ready++;
            if (bus.multdiv_stall !== 1'b0) n_stall++;
        end
        check("no ready after abort", n_ready, 0);
        check("no stall after abort", n_stall, 0);
        do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "post_reset_mul");

        for (int i = 0; i < 40; i++) begin
            rdiv = 1'($urandom_range(0, 1));
            ra   = pick_operand();
            rb   = pick_operand();
            ref_model(rdiv, ra, rb, eo, ee);
            do_op(rdiv, ra, rb, eo, ee, rdiv ? "rand_div" : "rand_mul");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
